// File: rtl/serdesphy_tx_fifo_param.sv
// Parametrised show-ahead TX FIFO between the parallel TX interface and the serialiser.
// Optional half-width write packing is enabled by defining SERDESPHY_TXFIFO_PACK_EN.
module serdesphy_tx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_status
);

  localparam int PW   = ADDR_WIDTH + 1;
  localparam int HALF = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic                  overflow_reg, underflow_reg;

  logic                  req_wr, req_rd;
  logic                  push, pop;
  logic                  wr_err, rd_err;
  logic [DATA_WIDTH-1:0] wr_word;

  // Flags decode from the registered pointers only; the extra wrap bit separates full from empty.
  assign level        = wr_ptr_reg - rd_ptr_reg;
  assign full         = (level == PW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (int'(level) >= AF_THRESH);
  assign almost_empty = (int'(level) <= AE_THRESH);

  assign rd_data  = empty ? '0 : mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
  assign rd_valid = enable & rd_en & ~empty;

  // A flush overrides any same-cycle transfer, so requests are masked by it.
  assign req_wr = enable & wr_en & ~flush;
  assign req_rd = enable & rd_en & ~flush;
  assign pop    = req_rd & ~empty;
  assign rd_err = req_rd & empty;

`ifdef SERDESPHY_TXFIFO_PACK_EN
  logic            hold_valid_reg;
  logic [HALF-1:0] hold_data_reg;
  logic            commit;
  logic            unused_hi;

  assign unused_hi = ^wr_data[DATA_WIDTH-1:HALF];
  // Only the second half of a pair reaches the memory, so fullness is checked there alone.
  assign commit  = req_wr & hold_valid_reg;
  assign push    = commit & ~full;
  assign wr_err  = commit & full;
  assign wr_word = {wr_data[HALF-1:0], hold_data_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (flush) begin
      hold_valid_reg <= 1'b0;
    end else if (req_wr) begin
      hold_valid_reg <= ~hold_valid_reg;
      if (!hold_valid_reg) hold_data_reg <= wr_data[HALF-1:0];
    end
  end
`else
  assign push    = req_wr & ~full;
  assign wr_err  = req_wr & full;
  assign wr_word = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // A new error in the same cycle as clr_status keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_err | (overflow_reg & ~clr_status);
      underflow_reg <= rd_err | (underflow_reg & ~clr_status);
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_serdesphy_tx_fifo_param.sv
// Directed self-checking bench for serdesphy_tx_fifo_param (default 8x8 configuration).
module tb_serdesphy_tx_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, flush, wr_en, rd_en, clr_status;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] level;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serdesphy_tx_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_status   (clr_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_status = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; wr_data = 8'h00;
    idle();
    #12;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef SERDESPHY_TXFIFO_PACK_EN
    wr_en = 1'b1; wr_data = 8'h03; tick();
    check("pk_half_level", level, 0);
    wr_data = 8'h0A; tick();
    wr_en = 1'b0;
    check("pk_pair_level", level, 1);
    check("pk_pair_data", rd_data, 8'hA3);
    flush = 1'b1; tick(); flush = 1'b0;
    wr_en = 1'b1; wr_data = 8'h07; tick(); wr_en = 1'b0;
    check("pk_single_level", level, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    check("pk_flush_level", level, 0);
    wr_en = 1'b1; wr_data = 8'h01; tick();
    wr_data = 8'h02; tick(); wr_en = 1'b0;
    check("pk_fresh_level", level, 1);
    check("pk_fresh_data", rd_data, 8'h21);
`else
    // 1: fill with 0x11..0x88 and track the flags as the level rises
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 8'(i * 8'h11);
      tick();
      check("fill_level", level, i);
      check("fill_af", almost_full, (i >= 6));
      check("fill_full", full, (i == 8));
      check("fill_ae", almost_empty, (i <= 2));
    end
    wr_en = 1'b0;
    check("fill_head", rd_data, 8'h11);

    // 2: full + write + read -> pop goes ahead, write rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
    #1 check("full_rw_valid", rd_valid, 1);
    tick();
    idle();
    check("full_rw_level", level, 7);
    check("full_rw_overflow", overflow, 1);
    check("full_rw_full", full, 0);
    rd_en = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      check("drain_data", rd_data, 8'(i * 8'h11));
      tick();
    end
    rd_en = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_rd_data", rd_data, 0);

    // 3: empty + write + read -> write taken, pop refused
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5C;
    #1 check("empty_rw_valid", rd_valid, 0);
    tick();
    idle();
    check("empty_rw_underflow", underflow, 1);
    check("empty_rw_data", rd_data, 8'h5C);
    check("empty_rw_level", level, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("empty_rw_pop", level, 0);

    // 4: fill 5 then flush; afterwards stream across the pointer wrap
    wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("pre_flush_level", level, 5);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_rd_data", rd_data, 0);
    check("flush_overflow", overflow, 1);
    check("flush_underflow", underflow, 1);
    wr_en = 1'b1; wr_data = 8'h40; tick();
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(8'h41 + i);
      check("stream_data", rd_data, 8'(8'h40 + i));
      tick();
    end
    idle();
    check("stream_level", level, 1);
    check("stream_tail", rd_data, 8'h54);
    rd_en = 1'b1; tick(); rd_en = 1'b0;

    // 5: sticky clear, and a new error beating a simultaneous clear
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_underflow", underflow, 0);
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
    end
    check("refill_full", full, 1);
    clr_status = 1'b1; wr_data = 8'hEE; tick();
    idle();
    check("clr_vs_err_overflow", overflow, 1);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("clr_again_overflow", overflow, 0);

    // enable low freezes state and suppresses errors
    enable = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    #1 check("dis_rd_valid", rd_valid, 0);
    tick();
    idle(); enable = 1'b1;
    check("dis_level", level, 8);
    check("dis_overflow", overflow, 0);
    check("dis_head", rd_data, 8'hC0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
